// File: rtl/bus_pkg.sv
// Shared definitions for the 32-bit crossbar bus: width, command encoding and
// the responder state type.
package bus_pkg;

    localparam int Nr = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous word array. Writes and reads share one address port.
// The read data register only updates on a read access. Contents are never reset.
import bus_pkg::*;

module bus_mem_array #(
    parameter int DEPTH = 256,
    parameter int W     = Nr,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-backed crossbar slave. It accepts one request, waits LATENCY cycles,
// then returns a one-cycle ack with read data taken from the internal array.
import bus_pkg::*;

module bus_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [Nr-1:0] addr,
    input  logic          cmd,
    input  logic [Nr-1:0] wdata,
    output logic          ack,
    output logic [Nr-1:0] rdata,
    output logic          busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    resp_state_t   state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          cmd_reg, cmd_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic          ack_reg, ack_next;
    logic [Nr-1:0] rdata_reg, rdata_next;
    logic          busy_reg, busy_next;

    logic          accept;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [Nr-1:0] mem_q;

    // Slave-select and the bits above the index do not take part in decoding.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[Nr-1:AW];

    // The array is addressed straight from the bus on the acceptance edge.
    // A write lands there and then; a read parks its word in mem_q until RESP.
    assign mem_we   = accept && (cmd == CMD_WRITE);
    assign mem_addr = addr[AW-1:0];

    bus_mem_array #(
        .DEPTH (DEPTH),
        .W     (Nr)
    ) u_array (
        .clk   (clk),
        .en    (accept),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (wdata),
        .q     (mem_q)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cmd_next   = cmd_reg;
        idx_next   = idx_reg;
        rdata_next = rdata_reg;
        ack_next   = 1'b0;
        accept     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    cmd_next = cmd;
                    idx_next = addr[AW-1:0];
                    if (LATENCY == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                // ack and rdata are registered, so they appear in the IDLE cycle
                // that follows; a still-high req there is a new transaction.
                ack_next   = 1'b1;
                state_next = IDLE;
                if (cmd_reg == CMD_READ) begin
                    rdata_next = mem_q;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            cmd_reg   <= CMD_READ;
            idx_reg   <= '0;
            ack_reg   <= 1'b0;
            rdata_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cmd_reg   <= cmd_next;
            idx_reg   <= idx_next;
            ack_reg   <= ack_next;
            rdata_reg <= rdata_next;
            busy_reg  <= busy_next;
        end
    end

    assign ack   = ack_reg;
    assign rdata = rdata_reg;
    assign busy  = busy_reg;

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Memory-backed responder for the 32-bit crossbar bus. It answers one slave port of the crossbar: it accepts `req`/`addr`/`cmd`/`wdata`, performs a word read or write on an internal array, and returns `ack`/`rdata` after a programmable number of wait states. It is the slave-side counterpart of the bus masters and serves as both the functional endpoint and the latency model behind each crossbar output.

## Interface
- `Nr`, 32: bus data/address width, from the shared package.
- `DEPTH`, 256: number of `Nr`-bit words; must be a power of two, at least 2.
- `LATENCY`, 0: wait cycles between acceptance and response, 0 to 15.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  1  request from the crossbar; held high by the master until `ack`.
- `addr`  input  Nr  word address; `[Nr-1:Nr-2]` is the slave select and is ignored here; index is `addr[AW-1:0]`, with AW = $clog2(DEPTH).
- `cmd`  input  1  0 = read, 1 = write.
- `wdata`  input  Nr  write data.
- `ack`  output  1  one-cycle response strobe.
- `rdata`  output  Nr  read data, valid only in the `ack` cycle of a read.
- `busy`  output  1  high whenever the FSM is not IDLE.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: if `req`=1 at a rising edge, accept the request. Capture `addr`, `cmd` and `wdata`. Go to WAIT with the counter set to `LATENCY`-1, or go straight to RESP when `LATENCY`=0.
- A write updates the array on the acceptance edge.
- WAIT: the counter decrements each cycle. At 0 the FSM goes to RESP. Bus inputs are ignored.
- On entry to RESP:
  - `ack` is set to 1.
  - For a read, `rdata` is loaded from the array at the captured index.
  - For a write, `rdata` holds its previous value.
- RESP: `ack`=1 for exactly one cycle, then the FSM always goes to IDLE. `req` is ignored in RESP, because it is still the old request.
- Back-to-back: if `req` is still high in the IDLE cycle after RESP, it is a new transaction and is accepted normally.
- A read of an index written by the previous transaction returns the new data.
- The index wraps modulo DEPTH. Address bits between AW and `Nr-3` are ignored.
- `cmd`, `addr` and `wdata` changing during WAIT or RESP have no effect on the transaction in flight.

## Timing
- Reset values: state=IDLE, `ack`=0, `rdata`=0, `busy`=0, counter=0. The array is not reset and its contents are undefined.
- Outputs are registered, with no combinational path from inputs to outputs.
- Let `req` be first sampled high at edge k:
  - `ack` is high during the cycle after edge k+1+`LATENCY`.
  - The next acceptance happens no earlier than edge k+2+`LATENCY`.
- Throughput is one transaction per `LATENCY`+2 cycles.
- `busy` rises the cycle after acceptance and falls together with `ack`.
- Reset asserted mid-transaction clears `ack`/`rdata`/`busy` immediately (asynchronous) and abandons the pending response. A write already accepted stays in the array. After reset release, a held `req` is accepted as a fresh request.

## Structure
- Shared package `bus_pkg` holds:
  - `Nr`
  - `CMD_READ` = 1'b0 and `CMD_WRITE` = 1'b1
  - the state enum `resp_state_t` {IDLE, WAIT, RESP}
- Sub-module `bus_mem_array`: single-port synchronous array, DEPTH x Nr.
  - One write port with enable, plus a read port registered into `rdata` by the parent.
  - No reset on the array.
- The FSM, wait counter and capture registers live in `bus_mem_responder`.

## Test plan
- Reset check: assert `rst` with `req`=1 → `ack`=0, `rdata`=0 and `busy`=0 throughout reset.
- Write then read, `LATENCY`=0: write 32'hDEAD_BEEF to addr 32'h0000_0005, then read addr 32'hC000_0005.
  - `ack` comes 1 cycle after acceptance each time.
  - The read returns 32'hDEAD_BEEF, so slave-select bits are ignored.
- Latency, `LATENCY`=3: one read.
  - `ack` rises exactly 4 cycles after `req` is sampled and lasts 1 cycle.
  - `busy` is high for 4 cycles.
- Back-to-back: hold `req`=1 for 3 writes to indices 0, 1, 2 with data 1, 2, 3, then read them back.
  - `ack` is spaced `LATENCY`+2 cycles apart.
  - Reads return 1, 2, 3.
- Wrap, DEPTH=256: write 32'h1234_5678 to addr 32'h0000_0101, then read addr 1 → 32'h1234_5678.
- Reset mid-transaction, `LATENCY`=5: assert `rst` 2 cycles after acceptance.
  - `ack` never pulses for that request.
  - After release, a read of the same address returns the written data if the aborted request was a write.
